// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type, constants and counter-width helper for the hazard control unit.
package hazard_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, LD_WAIT = 2'd1, FLUSH = 2'd2} haz_state_t;
    localparam int REG_ZERO = 0;
    localparam int DEF_AW = 5;
    function automatic int cw_req(input int mem_lat, input int flush_slots);
        int m;
        int w;
        m = (mem_lat > flush_slots) ? mem_lat : flush_slots;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-side signals of the hazard control unit.
interface hazard_ctrl_unit_if #(parameter int AW = 5);
    logic stall_en, fwd_en;
    logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
    logic id_uses_rs, id_uses_rt, id_branch, id_jump, br_taken;
    logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
    logic pc_write, ifid_write, ifid_flush, ctrl_pass, busy;
    modport master (
        output stall_en, fwd_en, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_jump, br_taken,
               ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, mem_mem_read,
        input  pc_write, ifid_write, ifid_flush, ctrl_pass, busy
    );
    modport slave (
        input  stall_en, fwd_en, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_jump, br_taken,
               ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, mem_mem_read,
        output pc_write, ifid_write, ifid_flush, ctrl_pass, busy
    );
endinterface

// File: rtl/hazard_src_match.sv
// hazard_src_match: one destination/source dependency check; register 0 never matches.
module hazard_src_match import hazard_pkg::*; #(
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] d,
    input  logic [AW-1:0] s,
    input  logic          u,
    output logic          hit
);
    assign hit = u && (d != AW'(REG_ZERO)) && (d == s);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: RAW/control hazard interlock with multi-cycle load stall and multi-slot flush.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters with perf_clr.
module hazard_ctrl_unit import hazard_pkg::*; #(
    parameter int AW          = DEF_AW,
    parameter int MEM_LAT     = 1,
    parameter int FLUSH_SLOTS = 1,
    parameter int CW          = 4
) (
    input logic clk,
    input logic reset,
    hazard_ctrl_unit_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    input  logic        perf_clr,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);
    if (cw_req(MEM_LAT, FLUSH_SLOTS) > CW) begin : g_cw_chk
        $error("hazard_ctrl_unit: CW too narrow for MEM_LAT/FLUSH_SLOTS");
    end
    haz_state_t state;
    logic [CW-1:0] cnt;
    logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
    logic ex_hit, mem_hit, h_lu, h_bex, h_bmem, h_nf, raw, ctl, stall, flush;
    hazard_src_match #(.AW(AW)) u_ex_rs  (.d(hz.ex_rd),  .s(hz.id_rs), .u(hz.id_uses_rs), .hit(ex_rs_hit));
    hazard_src_match #(.AW(AW)) u_ex_rt  (.d(hz.ex_rd),  .s(hz.id_rt), .u(hz.id_uses_rt), .hit(ex_rt_hit));
    hazard_src_match #(.AW(AW)) u_mem_rs (.d(hz.mem_rd), .s(hz.id_rs), .u(hz.id_uses_rs), .hit(mem_rs_hit));
    hazard_src_match #(.AW(AW)) u_mem_rt (.d(hz.mem_rd), .s(hz.id_rt), .u(hz.id_uses_rt), .hit(mem_rt_hit));
    assign ex_hit  = ex_rs_hit || ex_rt_hit;
    assign mem_hit = mem_rs_hit || mem_rt_hit;
    assign h_lu    = hz.ex_mem_read && hz.ex_reg_write && ex_hit;
    assign h_bex   = hz.id_branch && hz.ex_reg_write && !hz.ex_mem_read && ex_hit;
    assign h_bmem  = hz.id_branch && hz.mem_mem_read && hz.mem_reg_write && mem_hit;
    assign h_nf    = !hz.fwd_en && ((hz.ex_reg_write && ex_hit) || (hz.mem_reg_write && mem_hit));
    assign raw     = hz.stall_en && !hz.id_jump && (h_lu || h_bex || h_bmem || h_nf);
    assign ctl     = hz.id_jump || (hz.id_branch && hz.br_taken);
    // Reset gates the decode so outputs fall back to defaults while it is held.
    assign stall = !reset && ((state == LD_WAIT) || (state == RUN && raw));
    assign flush = !reset && ((state == FLUSH) || (state == RUN && !raw && ctl));
    assign hz.pc_write   = !stall;
    assign hz.ifid_write = !(stall || flush);
    assign hz.ifid_flush = flush;
    assign hz.ctrl_pass  = !(stall || flush);
    assign hz.busy       = !reset && (state != RUN);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (raw && h_lu && MEM_LAT > 1) begin
                state <= LD_WAIT;
                cnt   <= CW'(MEM_LAT - 1);
            end else if (!raw && ctl && FLUSH_SLOTS > 1) begin
                state <= FLUSH;
                cnt   <= CW'(FLUSH_SLOTS - 1);
            end
        end else begin
            cnt   <= cnt - CW'(1);
            state <= (cnt == CW'(1)) ? RUN : state;
        end
    end
`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            stall_cycles <= (stall && stall_cycles != '1) ? stall_cycles + 32'd1 : stall_cycles;
            flush_cycles <= (flush && flush_cycles != '1) ? flush_cycles + 32'd1 : flush_cycles;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: table-driven scoreboard bench for hazard_ctrl_unit with MEM_LAT=3, FLUSH_SLOTS=2.
module tb_hazard_ctrl_unit;
    typedef struct {
        logic se, fe;
        logic [4:0] rs;
        logic urs;
        logic [4:0] rt;
        logic urt, br, tk, jmp;
        logic [4:0] exrd;
        logic exrw, exmr;
        logic [4:0] memrd;
        logic memrw, memmr;
        logic [4:0] exp;
    } vec_t;
    // expected = {pc_write, ifid_write, ifid_flush, ctrl_pass, busy}
    localparam logic [4:0] DEF = 5'b11010, STL = 5'b00000, STB = 5'b00001;
    localparam logic [4:0] FLS = 5'b10100, FLB = 5'b10101;
    logic clk = 0, reset = 1;
    int n_chk = 0, n_fail = 0;
    logic [4:0] sb[$];
    vec_t tbl[$];
    hazard_ctrl_unit_if #(.AW(5)) bus ();
`ifdef HAZ_PERF_CNT_EN
    logic perf_clr = 0;
    logic [31:0] stall_cycles, flush_cycles;
`endif
    hazard_ctrl_unit #(.AW(5), .MEM_LAT(3), .FLUSH_SLOTS(2), .CW(4)) dut (
        .clk(clk), .reset(reset), .hz(bus)
`ifdef HAZ_PERF_CNT_EN
        , .perf_clr(perf_clr), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic se, fe, input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt, br, tk, jmp,
                                input logic [4:0] exrd, input logic exrw, exmr,
                                input logic [4:0] memrd, input logic memrw, memmr,
                                input logic [4:0] exp);
        vec_t v;
        v.se = se; v.fe = fe; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.br = br; v.tk = tk; v.jmp = jmp; v.exrd = exrd; v.exrw = exrw; v.exmr = exmr;
        v.memrd = memrd; v.memrw = memrw; v.memmr = memmr; v.exp = exp;
        return v;
    endfunction
    task automatic apply(input vec_t v);
        bus.stall_en = v.se; bus.fwd_en = v.fe; bus.id_rs = v.rs; bus.id_uses_rs = v.urs;
        bus.id_rt = v.rt; bus.id_uses_rt = v.urt; bus.id_branch = v.br; bus.br_taken = v.tk;
        bus.id_jump = v.jmp; bus.ex_rd = v.exrd; bus.ex_reg_write = v.exrw; bus.ex_mem_read = v.exmr;
        bus.mem_rd = v.memrd; bus.mem_reg_write = v.memrw; bus.mem_mem_read = v.memmr;
    endtask
    task automatic check(input string nm);
        logic [4:0] act, exp;
        exp = sb.pop_front();
        act = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.ctrl_pass, bus.busy};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc/ifw/flush/pass/busy=%b, want %b", nm, act, exp);
        end
    endtask
    task automatic step(input vec_t v, input string nm);
        apply(v);
        sb.push_back(v.exp);
        @(negedge clk);
        check(nm);
        @(posedge clk);
        #1;
    endtask
    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask
    vec_t idle, lu;
    initial begin
        //        se fe rs urs rt urt br tk jmp exrd rw mr memrd rw mr exp
        idle = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
        lu   = mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, STL);
        tbl.push_back(idle);
        tbl.push_back(lu);
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STB));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STB));
        tbl.push_back(idle);
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, DEF));
        tbl.push_back(mk(1, 1, 0, 0, 9, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, DEF));
        tbl.push_back(mk(1, 1, 5, 1, 0, 0, 1, 1, 0, 5, 1, 0, 0, 0, 0, STL));
        tbl.push_back(mk(1, 1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, FLS));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLB));
        tbl.push_back(idle);
        tbl.push_back(mk(1, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 12, 1, 0, STL));
        tbl.push_back(mk(1, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 12, 1, 0, DEF));
        tbl.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, DEF));
        tbl.push_back(mk(1, 1, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 7, 1, 1, STL));
        tbl.push_back(idle);
        tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, FLS));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(1, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
        tbl.push_back(mk(1, 1, 0, 0, 4, 1, 0, 0, 0, 4, 0, 0, 4, 0, 0, DEF));
        tbl[18].exp = DEF;
        tbl[17].exp = FLB;
        apply(lu);
        sb.push_back(DEF);
        @(negedge clk);
        check("reset_state");
        @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));
        // abort a load wait partway through with an asynchronous reset
        step(lu, "rst_seq_lu");
        apply(idle);
        sb.push_back(STB);
        #2 check("rst_seq_wait");
        reset = 1;
        sb.push_back(DEF);
        #1 check("rst_async_default");
        apply(lu);
        sb.push_back(DEF);
        @(negedge clk);
        check("rst_held_with_hazard");
        @(posedge clk);
        #1 reset = 0;
        step(idle, "post_rst_run0");
        step(idle, "post_rst_run1");
`ifdef HAZ_PERF_CNT_EN
        step(lu, "perf_lu");
        step(tbl[2], "perf_w1");
        step(tbl[3], "perf_w2");
        step(idle, "perf_i0");
        step(tbl[16], "perf_jmp");
        step(tbl[17], "perf_f2");
        step(idle, "perf_i1");
        chk32("stall_cycles", stall_cycles, 32'd3);
        chk32("flush_cycles", flush_cycles, 32'd2);
        perf_clr = 1;
        @(posedge clk);
        #1 perf_clr = 0;
        chk32("stall_clr", stall_cycles, 32'd0);
        chk32("flush_clr", flush_cycles, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
